// File: rtl/mac_8bit_seq.sv
// mac_8bit_seq: sequencer that drives one 8-bit math-block MAC slice.
//
// Takes a stream of operand/coefficient beats over a valid/ready handshake, strobes the MAC
// once per beat (clearing or rounding on the first one), waits one drain cycle, then captures
// MAC_OUT and presents it as an 8-bit result over a valid/ready handshake.
//
// Optional feature (macro MAC_SEQ_ACC_CHAIN_EN): adds input CHAIN. When it is latched high,
// the first element neither clears nor rounds, so accumulation continues from the previous
// operation. VEC_LEN==0 with CHAIN=1 skips straight to DRAIN and re-reports MAC_OUT.
//
// Ports:
//   MAC_ACC_CLK          clock
//   acc_ff_rstn          synchronous active-low reset
//   START                start request, sampled only in IDLE
//   VEC_LEN              element count, latched at START, clamped to MAX_LEN
//   CFG_OUT_SEL/TC/RND/SAT  MAC configuration, latched at START
//   CHAIN                (optional) continue previous accumulation, latched at START
//   OPER_IN/COEF_IN      stream data; IN_VALID/IN_READY stream handshake
//   RESULT/RESULT_VALID/RESULT_READY  result handshake
//   BUSY                 high whenever not IDLE
//   MAC_*                control/data to the MAC slice; EFPGA_MATHB_CLK_EN is the accumulate
//                        strobe; MAC_OUT is the MAC result input

module mac_8bit_seq #(
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned LEN_WIDTH = 5
) (
    input  logic                 MAC_ACC_CLK,
    input  logic                 acc_ff_rstn,
    input  logic                 START,
    input  logic [LEN_WIDTH-1:0] VEC_LEN,
    input  logic [5:0]           CFG_OUT_SEL,
    input  logic                 CFG_TC,
    input  logic                 CFG_RND,
    input  logic                 CFG_SAT,
`ifdef MAC_SEQ_ACC_CHAIN_EN
    input  logic                 CHAIN,
`endif
    input  logic [7:0]           OPER_IN,
    input  logic [7:0]           COEF_IN,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [7:0]           RESULT,
    output logic                 RESULT_VALID,
    input  logic                 RESULT_READY,
    output logic                 BUSY,
    output logic [7:0]           MAC_OPER_DATA,
    output logic [7:0]           MAC_COEF_DATA,
    output logic                 EFPGA_MATHB_CLK_EN,
    output logic                 MAC_ACC_CLEAR,
    output logic                 MAC_ACC_RND,
    output logic                 MAC_ACC_SAT,
    output logic [5:0]           MAC_OUT_SEL,
    output logic                 MAC_TC,
    input  logic [7:0]           MAC_OUT
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StAcc   = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StHold  = 3'd4;

    localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(MAX_LEN);

    logic [2:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic [5:0]           out_sel_q, out_sel_d;
    logic                 tc_q, tc_d;
    logic                 rnd_q, rnd_d;
    logic                 sat_q, sat_d;
    logic                 chain_q, chain_d;
    logic [7:0]           oper_q, oper_d;
    logic [7:0]           coef_q, coef_d;
    logic [7:0]           result_q, result_d;
    logic                 rvalid_q, rvalid_d;
    logic                 chain_in;
    logic                 first_elem;

`ifdef MAC_SEQ_ACC_CHAIN_EN
    assign chain_in = CHAIN;
`else
    assign chain_in = 1'b0;
`endif

    assign cnt_inc = cnt_q + LEN_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        out_sel_d = out_sel_q;
        tc_d      = tc_q;
        rnd_d     = rnd_q;
        sat_d     = sat_q;
        chain_d   = chain_q;
        oper_d    = oper_q;
        coef_d    = coef_q;
        result_d  = result_q;
        rvalid_d  = rvalid_q;

        case (state_q)
            StIdle: begin
                if (START) begin
                    len_d     = (VEC_LEN > MaxLen) ? MaxLen : VEC_LEN;
                    out_sel_d = CFG_OUT_SEL;
                    tc_d      = CFG_TC;
                    rnd_d     = CFG_RND;
                    sat_d     = CFG_SAT;
                    chain_d   = chain_in;
                    cnt_d     = '0;
                    // A chained zero-length op only re-reports the existing accumulator.
                    state_d   = (chain_in && (VEC_LEN == '0)) ? StDrain : StLoad;
                end
            end
            StLoad: begin
                if (len_q == '0) begin
                    // Zero-length op: one strobe with zero operands clears the accumulator.
                    oper_d  = 8'h00;
                    coef_d  = 8'h00;
                    state_d = StAcc;
                end else if (IN_VALID) begin
                    oper_d  = OPER_IN;
                    coef_d  = COEF_IN;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                cnt_d   = cnt_inc;
                state_d = ((len_q == '0) || (cnt_inc == len_q)) ? StDrain : StLoad;
            end
            StDrain: begin
                result_d = MAC_OUT;
                rvalid_d = 1'b1;
                state_d  = StHold;
            end
            StHold: begin
                if (RESULT_READY) begin
                    rvalid_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge MAC_ACC_CLK) begin
        if (!acc_ff_rstn) begin
            state_q   <= StIdle;
            len_q     <= '0;
            cnt_q     <= '0;
            out_sel_q <= '0;
            tc_q      <= 1'b0;
            rnd_q     <= 1'b0;
            sat_q     <= 1'b0;
            chain_q   <= 1'b0;
            oper_q    <= '0;
            coef_q    <= '0;
            result_q  <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            out_sel_q <= out_sel_d;
            tc_q      <= tc_d;
            rnd_q     <= rnd_d;
            sat_q     <= sat_d;
            chain_q   <= chain_d;
            oper_q    <= oper_d;
            coef_q    <= coef_d;
            result_q  <= result_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Only the first strobe of a non-chained op seeds the accumulator.
    assign first_elem = (state_q == StAcc) && (cnt_q == '0) && !chain_q;

    // Rounding only makes sense when bits are shifted out; otherwise seed with a plain clear.
    assign MAC_ACC_RND   = first_elem && rnd_q && (out_sel_q != 6'd0);
    assign MAC_ACC_CLEAR = first_elem && !MAC_ACC_RND;

    assign EFPGA_MATHB_CLK_EN = (state_q == StAcc);
    assign IN_READY           = (state_q == StLoad) && (len_q != '0);
    assign BUSY               = (state_q != StIdle);
    assign MAC_OPER_DATA      = oper_q;
    assign MAC_COEF_DATA      = coef_q;
    assign MAC_ACC_SAT        = sat_q;
    assign MAC_OUT_SEL        = out_sel_q;
    assign MAC_TC             = tc_q;
    assign RESULT             = result_q;
    assign RESULT_VALID       = rvalid_q;

endmodule
